// File: rtl/wdt_apb_pkg.sv
// Shared watchdog definitions: bus configuration, register map, kick key
// and the byte-strobe merge used by the writable registers.
package wdt_apb_pkg;

    // Subset of the core configuration this peripheral depends on.
    typedef struct packed {
        int unsigned XLEN;
        logic        WDT_SUPPORTED;
        logic [63:0] WDT_BASE;
        logic [63:0] WDT_RANGE;
    } cvw_t;

    localparam cvw_t WDT_DEFAULT_CFG = '{
        XLEN:          32,
        WDT_SUPPORTED: 1'b1,
        WDT_BASE:      64'h0000_0000_1004_0000,
        WDT_RANGE:     64'h0000_0000_0000_00FF
    };

    // Only this exact value, written with all four byte lanes, restarts the count.
    localparam logic [31:0] WDT_KICK_KEY = 32'h5A5A_C3C3;

    // Register offsets within the 32-byte window (PADDR[7:5] are don't-care).
    localparam logic [4:0] WDT_CTRL   = 5'h00;
    localparam logic [4:0] WDT_LOAD   = 5'h04;
    localparam logic [4:0] WDT_COUNT  = 5'h08;
    localparam logic [4:0] WDT_KICK   = 5'h0C;
    localparam logic [4:0] WDT_STATUS = 5'h10;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wdt_apb_wdtcounter.sv
// Loadable 32-bit down-counter with a zero flag; load has priority over count.
module wdtcounter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] value,
    output logic [31:0] count,
    output logic        zero
);

    // Reload, decrement or hold the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    count <= '0;
        else if (load) count <= value;
        else if (en)   count <= count - 32'd1;
    end

    assign zero = (count == 32'd0);

endmodule

// File: rtl/wdt_apb.sv
// APB watchdog: first timeout raises WDTIntr, a second unkicked timeout with
// RSTEN set latches WDTResetReq until PRESETn.
module wdt_apb
    import wdt_apb_pkg::*;
#(
    parameter cvw_t P = WDT_DEFAULT_CFG
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic [7:0]            PADDR,
    input  logic [P.XLEN-1:0]     PWDATA,
    input  logic [P.XLEN/8-1:0]   PSTRB,
    input  logic                  PWRITE,
    input  logic                  PENABLE,
    output logic [P.XLEN-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  WDTIntr,
    output logic                  WDTResetReq
);

    typedef enum logic [1:0] {IDLE, RUN, WARN, BITE} state_t;

    state_t      state, state_next;
    logic        ctrl_en, ctrl_en_next;
    logic        ctrl_rsten, ctrl_rsten_next;
    logic        ctrl_lock, ctrl_lock_next;
    logic [31:0] load_q, load_next;
    logic        intp, intp_next;
    logic [31:0] count;
    logic        count_zero, cnt_load, cnt_en, timeout;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [4:0]  offset;
    logic        wr_commit, kick, w1c;
    logic        unused_paddr;

    assign offset       = PADDR[4:0];
    assign unused_paddr = &{1'b0, PADDR[7:5]};
    assign wr_commit    = PSEL & PENABLE & PWRITE;
    assign PREADY       = 1'b1;

    // On a 64-bit bus, PADDR[2] picks the upper word lane and its strobes.
    generate
        if (P.XLEN == 64) begin : g_lane64
            assign wdata = PADDR[2] ? PWDATA[63:32] : PWDATA[31:0];
            assign wstrb = PADDR[2] ? PSTRB[7:4]    : PSTRB[3:0];
        end else begin : g_lane32
            assign wdata = PWDATA;
            assign wstrb = PSTRB;
        end
    endgenerate

    // Nothing software writes can disturb a bitten watchdog.
    assign kick = wr_commit && (offset == WDT_KICK) && (wstrb == 4'hF)
               && (wdata == WDT_KICK_KEY) && (state != BITE);
    assign w1c  = wr_commit && (offset == WDT_STATUS) && wdata[0] && (state != BITE);

    // Register writes, FSM next state and counter control.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next      = state;
        ctrl_en_next    = ctrl_en;
        ctrl_rsten_next = ctrl_rsten;
        ctrl_lock_next  = ctrl_lock;
        load_next       = load_q;
        intp_next       = intp;
        cnt_load        = 1'b0;
        cnt_en          = 1'b0;
        timeout         = 1'b0;

        // All CTRL bits live in byte 0; LOCK can only be set since writes stop once it is.
        if (wr_commit && (offset == WDT_CTRL) && !ctrl_lock && wstrb[0]) begin
            if (state != BITE) ctrl_en_next = wdata[0];
            ctrl_rsten_next = wdata[1];
            ctrl_lock_next  = wdata[2];
        end
        if (wr_commit && (offset == WDT_LOAD) && !ctrl_lock)
            load_next = apply_strb(load_q, wdata, wstrb);

        // Clearing EN beats a kick, which beats a timeout.
        case (state)
            IDLE: begin
                if (ctrl_en_next) begin
                    cnt_load   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN, WARN: begin
                if (!ctrl_en_next) begin
                    state_next = IDLE;
                end else if (kick) begin
                    cnt_load   = 1'b1;
                    state_next = RUN;
                end else if (count_zero) begin
                    timeout    = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = (state == WARN && ctrl_rsten_next) ? BITE : WARN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            BITE: state_next = BITE;
        endcase

        // A timeout setting INTP outranks a same-cycle W1C.
        if (w1c)     intp_next = 1'b0;
        if (timeout) intp_next = 1'b1;
    end

    // State and register flops.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        // NOTE: non-blocking assignments let every flop sample pre-edge values.
        if (!PRESETn) begin
            state      <= IDLE;
            ctrl_en    <= 1'b0;
            ctrl_rsten <= 1'b0;
            ctrl_lock  <= 1'b0;
            load_q     <= 32'hFFFF_FFFF;
            intp       <= 1'b0;
        end else begin
            state      <= state_next;
            ctrl_en    <= ctrl_en_next;
            ctrl_rsten <= ctrl_rsten_next;
            ctrl_lock  <= ctrl_lock_next;
            load_q     <= load_next;
            intp       <= intp_next;
        end
    end

    wdtcounter u_counter (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .load  (cnt_load),
        .en    (cnt_en),
        .value (load_q),
        .count (count),
        .zero  (count_zero)
    );

    // Read mux; the 32-bit value is replicated across the bus width.
    always_comb begin
        rdata = '0;
        case (offset)
            WDT_CTRL:   rdata = {29'b0, ctrl_lock, ctrl_rsten, ctrl_en};
            WDT_LOAD:   rdata = load_q;
            WDT_COUNT:  rdata = count;
            WDT_STATUS: rdata = {30'b0, (state == BITE), intp};
            default:    rdata = '0;
        endcase
    end

    assign PRDATA      = PSEL ? {(P.XLEN/32){rdata}} : '0;
    assign WDTIntr     = intp;
    assign WDTResetReq = (state == BITE);

endmodule

// File: tb/tb_wdt_apb.sv
// Bench for wdt_apb on a 64-bit bus: register table, directed corner cases,
// then random traffic checked cycle by cycle against a behavioural model.
module tb_wdt_apb;
    import wdt_apb_pkg::*;

    localparam cvw_t TB_CFG = '{XLEN: 64, WDT_SUPPORTED: 1'b1,
                                WDT_BASE: 64'h1004_0000, WDT_RANGE: 64'hFF};
    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PWRITE = 1'b0, PENABLE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [63:0] PWDATA = '0;
    logic [7:0]  PSTRB = '0;
    logic [63:0] PRDATA;
    logic        PREADY, WDTIntr, WDTResetReq;

    int n_checks = 0;
    int n_fail = 0;
    int intr_cycles = 0;

    // Model: phase 0 idle, 1 run, 2 warn, 3 bitten.
    bit          m_en, m_rsten, m_lock, m_intp;
    logic [31:0] m_load, m_count;
    int          m_phase;

    wdt_apb #(.P(TB_CFG)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .WDTIntr(WDTIntr), .WDTResetReq(WDTResetReq)
    );

    always #10 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset;
        m_en = 0; m_rsten = 0; m_lock = 0; m_intp = 0;
        m_load = 32'hFFFF_FFFF; m_count = 0; m_phase = 0;
    endtask

    // One clock of watchdog behaviour given this cycle's bus activity.
    task automatic model_step(input bit commit, input logic [7:0] addr,
                              input logic [63:0] d, input logic [7:0] s);
        logic [4:0]  off;
        logic [31:0] ld, c, old_load;
        logic [3:0]  ls;
        bit kick, w1c, tmo;
        off = addr[4:0];
        ld  = addr[2] ? d[63:32] : d[31:0];
        ls  = addr[2] ? s[7:4] : s[3:0];
        old_load = m_load;
        kick = commit && off == 5'h0C && ls == 4'hF && ld == KEY && m_phase != 3;
        w1c  = commit && off == 5'h10 && ld[0] && m_phase != 3;
        tmo  = 0;
        if (commit && off == 5'h00 && !m_lock) begin
            c = mrg({29'b0, m_lock, m_rsten, m_en}, ld, ls);
            if (m_phase != 3) m_en = c[0];
            m_rsten = c[1];
            m_lock  = m_lock | c[2];
        end
        if (commit && off == 5'h04 && !m_lock) m_load = mrg(m_load, ld, ls);
        if (m_phase == 0) begin
            if (m_en) begin m_count = old_load; m_phase = 1; end
        end else if (m_phase != 3) begin
            if (!m_en) m_phase = 0;
            else if (kick) begin m_count = old_load; m_phase = 1; end
            else if (m_count == 0) begin
                tmo = 1;
                m_count = old_load;
                m_phase = (m_phase == 2 && m_rsten) ? 3 : 2;
            end else m_count = m_count - 1;
        end
        if (w1c) m_intp = 0;
        if (tmo) m_intp = 1;
    endtask

    // Drive one cycle of bus signals, advance the model, check the outputs.
    task automatic tick(input logic sel, input logic en, input logic wr, input logic [7:0] addr,
                        input logic [63:0] d, input logic [7:0] s);
        @(negedge PCLK);
        PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = d; PSTRB = s;
        model_step(sel & en & wr, addr, d, s);
        @(posedge PCLK);
        #1;
        if (WDTIntr) intr_cycles++;
        check("model_intr", 64'(WDTIntr), 64'(m_intp));
        check("model_resetreq", 64'(WDTResetReq), 64'(m_phase == 3));
    endtask

    task automatic tick_idle;
        tick(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    endtask

    task automatic wr64(input logic [7:0] addr, input logic [63:0] d, input logic [7:0] s);
        tick(1'b1, 1'b0, 1'b1, addr, d, s);
        tick(1'b1, 1'b1, 1'b1, addr, d, s);
    endtask

    task automatic wr32(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s);
        wr64(addr, addr[2] ? {d, 32'h0} : {32'h0, d}, addr[2] ? {s, 4'h0} : {4'h0, s});
    endtask

    // Combinational read inside the current cycle; consumes no clock edge.
    task automatic peek(input logic [7:0] addr, output logic [63:0] v);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        #1;
        v = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic peek_check(input string name, input logic [7:0] addr, input logic [63:0] exp);
        logic [63:0] v;
        peek(addr, v);
        check(name, v, exp);
    endtask

    task automatic do_reset;
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        #2 PRESETn = 1'b0;
        #1;
        check("async_rst_intr", 64'(WDTIntr), 64'd0);
        check("async_rst_req", 64'(WDTResetReq), 64'd0);
        model_reset();
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
    endtask

    // Idle until COUNT reads 1, so the next write commits on the COUNT==0 cycle.
    task automatic wait_count1(input string name);
        logic [63:0] v;
        int k;
        for (k = 0; k < 64; k++) begin
            peek(8'h08, v);
            if (v[31:0] == 32'd1) break;
            tick_idle();
        end
        check(name, 64'(k < 64), 64'd1);
    endtask

    task automatic wait_event(input bit want_req, output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            tick_idle();
            if ((want_req ? WDTResetReq : WDTIntr) === 1'b1) begin lat = k; break; end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit wr, input logic [7:0] addr, input logic [63:0] data,
                       input logic [7:0] strb, input logic [63:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] v, c0, c1;
        int lat, i0, r;
        logic [31:0] d;
        logic [3:0]  s4;
        logic [4:0]  off;

        add(0, 8'h00, 64'h0, 8'h00, 64'h0, "rst_ctrl");
        add(0, 8'h04, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, "rst_load");
        add(0, 8'h08, 64'h0, 8'h00, 64'h0, "rst_count");
        add(0, 8'h10, 64'h0, 8'h00, 64'h0, "rst_status");
        add(0, 8'h0C, 64'h0, 8'h00, 64'h0, "kick_reads_zero");
        add(1, 8'h04, 64'h1234_5678_0000_0000, 8'hF0, 64'h0, "");
        add(0, 8'h04, 64'h0, 8'h00, 64'h1234_5678_1234_5678, "load_full");
        add(1, 8'h04, 64'hAABB_CCDD_0000_0000, 8'h50, 64'h0, "");
        add(0, 8'h04, 64'h0, 8'h00, 64'h12BB_56DD_12BB_56DD, "load_strobed");
        add(1, 8'h04, 64'h0000_0000_9999_9999, 8'h0F, 64'h0, "");
        add(0, 8'h04, 64'h0, 8'h00, 64'h12BB_56DD_12BB_56DD, "load_wrong_lane");
        add(0, 8'hE4, 64'h0, 8'h00, 64'h12BB_56DD_12BB_56DD, "addr_alias");
        add(1, 8'h00, 64'h0000_0000_0000_0002, 8'h01, 64'h0, "");
        add(0, 8'h00, 64'h0, 8'h00, 64'h0000_0002_0000_0002, "ctrl_rsten");
        add(1, 8'h08, 64'h0000_0000_0000_0055, 8'hFF, 64'h0, "");
        add(0, 8'h08, 64'h0, 8'h00, 64'h0, "count_ro");
        add(1, 8'h14, 64'h0000_0000_FFFF_FFFF, 8'hFF, 64'h0, "");
        add(0, 8'h14, 64'h0, 8'h00, 64'h0, "unmapped_reads_zero");
        add(1, 8'h00, 64'h0, 8'hFF, 64'h0, "");
        add(0, 8'h00, 64'h0, 8'h00, 64'h0, "ctrl_cleared");
        add(1, 8'h04, 64'h0000_0040_FFFF_FFFF, 8'hF0, 64'h0, "");
        add(0, 8'h04, 64'h0, 8'h00, 64'h0000_0040_0000_0040, "xlen64_lane");

        model_reset();
        do_reset();
        check("pready", 64'(PREADY), 64'd1);
        foreach (vecs[i]) begin
            if (vecs[i].wr) wr64(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else            peek_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        PSEL = 1'b0; PADDR = 8'h04;
        #1 check("prdata_unselected", PRDATA, 64'h0);

        // Interrupt latency and W1C.
        do_reset();
        wr32(8'h04, 32'd10, 4'hF);
        wr32(8'h00, 32'h1, 4'hF);
        peek_check("en_loads_count", 8'h08, {2{32'd10}});
        wait_event(0, lat);
        check("intr_latency", 64'(lat), 64'd11);
        peek_check("reload_on_timeout", 8'h08, {2{32'd10}});
        wr32(8'h10, 32'h1, 4'hF);
        check("w1c_clears_intr", 64'(WDTIntr), 64'd0);

        // Bite and its stickiness.
        do_reset();
        wr32(8'h04, 32'd5, 4'hF);
        wr32(8'h00, 32'h3, 4'hF);
        wait_event(1, lat);
        check("bite_latency", 64'(lat), 64'd12);
        wr32(8'h0C, KEY, 4'hF);
        wr32(8'h00, 32'h0, 4'hF);
        wr32(8'h10, 32'h1, 4'hF);
        check("bite_sticky_req", 64'(WDTResetReq), 64'd1);
        check("bite_intp_held", 64'(WDTIntr), 64'd1);
        peek_check("bite_status", 8'h10, {2{32'h3}});
        do_reset();
        check("reset_clears_req", 64'(WDTResetReq), 64'd0);
        peek_check("reset_status", 8'h10, 64'h0);

        // Regular kicks hold off the timeout; malformed kicks do not.
        wr32(8'h04, 32'd20, 4'hF);
        wr32(8'h00, 32'h1, 4'hF);
        i0 = intr_cycles;
        for (int n = 0; n < 14; n++) begin
            repeat (13) tick_idle();
            wr32(8'h0C, KEY, 4'hF);
        end
        check("kicked_no_intr", 64'(intr_cycles - i0), 64'd0);
        peek(8'h08, c0);
        wr32(8'h0C, 32'h5A5A_C3C2, 4'hF);
        peek(8'h08, c1);
        check("bad_key_ignored", c1, {2{c0[31:0] - 32'd2}});
        wr32(8'h0C, KEY, 4'h7);
        peek(8'h08, c0);
        check("partial_strb_ignored", c0, {2{c1[31:0] - 32'd2}});
        wait_event(0, lat);
        check("timeout_after_bad_kicks", 64'(lat), 64'(c0[31:0] + 32'd1));

        // LOCK freezes CTRL and LOAD; a kick on COUNT==0 beats the timeout.
        do_reset();
        wr32(8'h04, 32'd10, 4'hF);
        wr32(8'h00, 32'h7, 4'hF);
        wr32(8'h00, 32'h0, 4'hF);
        wr32(8'h04, 32'd3, 4'hF);
        peek_check("lock_ctrl", 8'h00, {2{32'h7}});
        peek_check("lock_load", 8'h04, {2{32'd10}});
        peek_check("lock_counting", 8'h08, {2{32'd6}});
        wait_count1("lock_reach_one");
        wr32(8'h0C, KEY, 4'hF);
        peek_check("kick_at_zero_reload", 8'h08, {2{32'd10}});
        check("kick_at_zero_no_intr", 64'(WDTIntr), 64'd0);
        peek_check("kick_at_zero_status", 8'h10, 64'h0);

        // EN clear and W1C landing on a timeout cycle.
        do_reset();
        wr32(8'h04, 32'd4, 4'hF);
        wr32(8'h00, 32'h1, 4'hF);
        wait_count1("en_clear_reach_one");
        wr32(8'h00, 32'h0, 4'hF);
        check("en_clear_wins_intr", 64'(WDTIntr), 64'd0);
        peek_check("en_clear_count_held", 8'h08, 64'h0);
        wr32(8'h00, 32'h1, 4'hF);
        wait_count1("w1c_reach_one");
        wr32(8'h10, 32'h1, 4'hF);
        check("timeout_beats_w1c", 64'(WDTIntr), 64'd1);
        peek_check("timeout_reload", 8'h08, {2{32'd4}});

        // Random traffic against the model.
        for (int it = 0; it < 1500; it++) begin
            r  = $urandom_range(0, 199);
            s4 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            if (r < 100) begin
                tick_idle();
                peek_check("rnd_count", 8'h08, {2{m_count}});
                peek_check("rnd_status", 8'h10, {2{30'b0, m_phase == 3, m_intp}});
                peek_check("rnd_ctrl", 8'h00, {2{29'b0, m_lock, m_rsten, m_en}});
                peek_check("rnd_load", 8'h04, {2{m_load}});
            end else if (r == 199) begin
                do_reset();
            end else begin
                if (r < 120)      begin off = 5'h04; d = 32'($urandom_range(0, 6)); end
                else if (r < 140) begin
                    off = 5'h00;
                    d = 32'($urandom_range(0, 3)) | (($urandom_range(0, 39) == 0) ? 32'h4 : 32'h0);
                end
                else if (r < 165) begin
                    off = 5'h0C;
                    d = ($urandom_range(0, 2) == 0) ? (KEY ^ (32'h1 << $urandom_range(0, 31))) : KEY;
                end
                else if (r < 185) begin off = 5'h10; d = $urandom; end
                else              begin off = 5'($urandom_range(0, 31)); d = $urandom; end
                wr32({3'($urandom_range(0, 7)), off}, d, s4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
